led_flow_ctrl: RTL and testbench

- Sequencer and controller for the 8-LED flowing-light datapath on the board.
- Owns the prescaler, selects the flow pattern and the speed, and optionally pauses the flow.
- Takes three already-debounced push-button levels and drives the LED bar directly.
- Sits between the board button pins and the LED pins; replaces a fixed-pattern free-running shifter.

---
 rtl/led_flow_pkg.sv | 27 ++
 rtl/led_flow_prescaler.sv | 33 +++
 rtl/led_flow_ctrl.sv | 118 +++++++++++
 tb/tb_led_flow_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_flow_pkg.sv
// Shared types and constants for the 8-LED flowing-light controller.
package led_flow_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  typedef logic [1:0] speed_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [7:0] LED_FIRST = 8'h01;
  localparam logic [7:0] LED_LAST  = 8'h80;
  localparam logic [7:0] LED_FULL  = 8'hFF;

  // Pattern loaded whenever a mode is entered.
  function automatic logic [7:0] start_pattern(input mode_t m);
    return (m == MODE_RIGHT) ? LED_LAST : LED_FIRST;
  endfunction

endpackage

// File: rtl/led_flow_prescaler.sv
// Step-rate prescaler: wraps at a speed-dependent terminal count and strobes tick.
module led_flow_prescaler
  import led_flow_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] speed,
  input  logic       clear,
  input  logic       freeze,
  output logic       tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term;

  // Each speed level divides the step period by four.
  assign term = {CNT_W{1'b1}} >> {speed, 1'b0};
  assign tick = (count == term) && !freeze;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!freeze) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// Flowing-light sequencer: button edge detect, mode/speed selection and LED pattern FSM.
// Optional pause button enabled by defining LED_FLOW_PAUSE_EN.
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int LED_N = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             btn_mode,
  input  logic             btn_speed,
  input  logic             btn_pause,
  output logic [LED_N-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             tick,
  output logic             paused
);

  logic             btn_mode_q, btn_speed_q;
  logic             rise_mode, rise_speed;
  logic             clear, step, paused_q;
  mode_t            mode_q, mode_d;
  speed_t           speed_q, speed_d;
  dir_t             dir_q, dir_d;
  logic [LED_N-1:0] led_q, led_d;

  assign rise_mode  = btn_mode & ~btn_mode_q;
  assign rise_speed = btn_speed & ~btn_speed_q;
  assign clear      = rise_mode | rise_speed;
  // A mode or speed event always wins over a coincident tick.
  assign step       = tick & ~clear;

  led_flow_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .speed  (speed_q),
    .clear  (clear),
    .freeze (paused_q),
    .tick   (tick)
  );

`ifdef LED_FLOW_PAUSE_EN
  logic btn_pause_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_pause_q <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      btn_pause_q <= btn_pause;
      if (btn_pause & ~btn_pause_q) paused_q <= ~paused_q;
    end
  end
`else
  logic unused_btn_pause;
  assign unused_btn_pause = btn_pause;
  assign paused_q         = 1'b0;
`endif

  // NOTE: the reset branch is asynchronous, so outputs return to idle without waiting for a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_mode_q  <= 1'b0;
      btn_speed_q <= 1'b0;
      mode_q      <= MODE_LEFT;
      speed_q     <= '0;
      dir_q       <= DIR_UP;
      led_q       <= LED_FIRST;
    end else begin
      btn_mode_q  <= btn_mode;
      btn_speed_q <= btn_speed;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
    end
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    led_d   = led_q;

    if (rise_speed) speed_d = speed_q + 2'd1;

    if (rise_mode) begin
      mode_d = mode_t'(mode_q + 2'd1);
      dir_d  = DIR_UP;
      led_d  = start_pattern(mode_d);
    end else if (step) begin
      unique case (mode_q)
        MODE_LEFT:  led_d = (led_q == LED_LAST)  ? LED_FIRST : {led_q[LED_N-2:0], 1'b0};
        MODE_RIGHT: led_d = (led_q == LED_FIRST) ? LED_LAST  : {1'b0, led_q[LED_N-1:1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            led_d = {led_q[LED_N-2:0], 1'b0};
            if (led_d == LED_LAST) dir_d = DIR_DOWN;
          end else begin
            led_d = {1'b0, led_q[LED_N-1:1]};
            if (led_d == LED_FIRST) dir_d = DIR_UP;
          end
        end
        MODE_FILL:  led_d = (led_q == LED_FULL) ? LED_FIRST : {led_q[LED_N-2:0], 1'b1};
        default:    led_d = led_q;
      endcase
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench for led_flow_ctrl (CNT_W=4): vector table with an LED scoreboard plus corner sequences.
module tb_led_flow_ctrl;

  localparam int CNT_W = 4;
  localparam int NV    = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_mode = 1'b0, btn_speed = 1'b0, btn_pause = 1'b0;
  logic [7:0] led;
  logic [1:0] mode, speed;
  logic       tick, paused;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int               sp;      // speed pulses applied after reset
    int               md;      // mode pulses applied after the speed pulses (>= 1)
    logic [1:0]       mode;
    logic [1:0]       speed;
    int               period;  // expected cycles between ticks
    logic [7:0]       start;
    int               nsteps;
    logic [15:0][7:0] seq;     // seq[15] is the first step
  } vec_t;

  vec_t vecs[NV];

  led_flow_ctrl #(.CNT_W(CNT_W), .LED_N(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .led       (led),
    .mode      (mode),
    .speed     (speed),
    .tick      (tick),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (tick !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    if (tick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    btn_mode = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; cyc(); btn_mode = 1'b0; cyc();
  endtask

  task automatic pulse_speed();
    btn_speed = 1'b1; cyc(); btn_speed = 1'b0; cyc();
  endtask

  initial begin
    int         n;
    int         bad;
    logic [7:0] exp_led;

    vecs[0] = '{sp:0, md:4, mode:2'd0, speed:2'd0, period:16, start:8'h01, nsteps:8,
                seq:{8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h01,
                     8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
    vecs[1] = '{sp:1, md:4, mode:2'd0, speed:2'd1, period:4, start:8'h01, nsteps:4,
                seq:{8'h02,8'h04,8'h08,8'h10,8'h00,8'h00,8'h00,8'h00,
                     8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
    vecs[2] = '{sp:3, md:2, mode:2'd2, speed:2'd3, period:1, start:8'h01, nsteps:16,
                seq:{8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h40,
                     8'h20,8'h10,8'h08,8'h04,8'h02,8'h01,8'h02,8'h04}};
    vecs[3] = '{sp:4, md:3, mode:2'd3, speed:2'd0, period:16, start:8'h01, nsteps:8,
                seq:{8'h03,8'h07,8'h0F,8'h1F,8'h3F,8'h7F,8'hFF,8'h01,
                     8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
    vecs[4] = '{sp:2, md:1, mode:2'd1, speed:2'd2, period:1, start:8'h80, nsteps:8,
                seq:{8'h40,8'h20,8'h10,8'h08,8'h04,8'h02,8'h01,8'h80,
                     8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
    vecs[5] = '{sp:3, md:5, mode:2'd1, speed:2'd3, period:1, start:8'h80, nsteps:3,
                seq:{8'h40,8'h20,8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,
                     8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};

    // Reset values, then the free-running LEFT flow and its first-tick latency.
    cyc();
    check("rst_led", led, 8'h01);
    check("rst_mode", mode, 2'd0);
    check("rst_speed", speed, 2'd0);
    check("rst_tick", tick, 1'b0);
    check("rst_paused", paused, 1'b0);
    rstn = 1'b1;
    wait_tick(64, n);
    check("first_tick_gap", n, 15);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check($sformatf("left_step%0d", i), led, (i == 7) ? 8'h01 : (8'h02 << i));
      if (i < 7) begin
        wait_tick(64, n);
        check($sformatf("left_gap%0d", i), n, 15);
      end
    end

    // Table-driven vectors with the expected LED steps queued up front.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].sp; k++) pulse_speed();
      for (int k = 0; k < vecs[v].md - 1; k++) pulse_mode();
      btn_mode = 1'b1;
      cyc();
      check($sformatf("v%0d_mode", v), mode, vecs[v].mode);
      check($sformatf("v%0d_speed", v), speed, vecs[v].speed);
      check($sformatf("v%0d_start", v), led, vecs[v].start);
      btn_mode = 1'b0;
      for (int i = 0; i < vecs[v].nsteps; i++) exp_q.push_back(vecs[v].seq[15-i]);
      for (int i = 0; i < vecs[v].nsteps; i++) begin
        wait_tick(64, n);
        check($sformatf("v%0d_period%0d", v, i), n + 1, vecs[v].period);
        cyc();
        exp_led = exp_q.pop_front();
        check($sformatf("v%0d_led%0d", v, i), led, exp_led);
      end
    end

    // Mode event in the tick cycle: reload wins, count restarts; a held level counts once.
    do_reset();
    wait_tick(64, n);
    btn_mode = 1'b1;
    cyc();
    check("mode_beats_tick_led", led, 8'h80);
    check("mode_beats_tick_mode", mode, 2'd1);
    wait_tick(64, n);
    check("mode_clears_count", n, 15);
    for (int k = 0; k < 34; k++) cyc();
    check("held_level_one_event", mode, 2'd1);
    btn_mode = 1'b0;

    // Speed event in the tick cycle suppresses the step; then simultaneous events; then async reset.
    do_reset();
    wait_tick(64, n);
    btn_speed = 1'b1;
    cyc();
    check("speed_suppress_led", led, 8'h01);
    check("speed_suppress_speed", speed, 2'd1);
    btn_speed = 1'b0;
    wait_tick(64, n);
    check("speed1_gap", n, 3);
    cyc();
    check("speed1_step", led, 8'h02);
    btn_mode = 1'b1; btn_speed = 1'b1;
    cyc();
    check("both_mode", mode, 2'd1);
    check("both_speed", speed, 2'd2);
    check("both_led", led, 8'h80);
    btn_mode = 1'b0; btn_speed = 1'b0;
    cyc(); cyc(); cyc();
    rstn = 1'b0;
    #1;
    check("midrun_rst_led", led, 8'h01);
    check("midrun_rst_mode", mode, 2'd0);
    check("midrun_rst_speed", speed, 2'd0);
    check("midrun_rst_tick", tick, 1'b0);

`ifdef LED_FLOW_PAUSE_EN
    // Pause at led=08: everything frozen, then resume from the held count.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_tick(64, n);
      cyc();
    end
    check("pause_pre_led", led, 8'h08);
    btn_pause = 1'b1;
    cyc();
    check("pause_on", paused, 1'b1);
    btn_pause = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (tick !== 1'b0 || led !== 8'h08) bad++;
    end
    check("pause_hold_bad_cycles", bad, 0);
    btn_pause = 1'b1;
    cyc();
    check("pause_off", paused, 1'b0);
    btn_pause = 1'b0;
    wait_tick(64, n);
    check("resume_held_count", n, 14);
    cyc();
    check("resume_step", led, 8'h10);
    pulse_speed();
    btn_pause = 1'b1; cyc(); btn_pause = 1'b0;
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    check("paused_mode_event", mode, 2'd1);
    check("paused_mode_led", led, 8'h80);
    check("paused_stays", paused, 1'b1);
`else
    // Without the feature the pause button has no effect.
    do_reset();
    btn_pause = 1'b1;
    cyc();
    check("nopause_flag", paused, 1'b0);
    btn_pause = 1'b0;
    wait_tick(64, n);
    check("nopause_gap", n, 14);
    cyc();
    check("nopause_step", led, 8'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
